button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEFAULT, default 0: debounced level held from reset and before the first qualified change.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1000000: consecutive samples of a new value needed to accept it; legal range 1 or more.
REQ-003 SHALL have parameter REPEAT_ENABLE, default 0: 1 enables auto-repeat while the level is held high.
REQ-004 SHALL have parameter REPEAT_DELAY, default 50000000: cycles from press_pulse to the first repeat_pulse; legal range 1 or more.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between successive repeat_pulse outputs; legal range 1 or more.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port sync_input, input, 1 bit: a button level already synchronized to clock; it may bounce.
REQ-009 SHALL have port level, output, 1 bit: the debounced level, registered.
REQ-010 SHALL have port press_pulse, output, 1 bit: high for one cycle on an accepted 0 to 1 change.
REQ-011 SHALL have port release_pulse, output, 1 bit: high for one cycle on an accepted 1 to 0 change.
REQ-012 SHALL have port repeat_pulse, output, 1 bit: high for one cycle per auto-repeat event.

Function
REQ-013 SHALL implement a four-state FSM: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-014 SHALL move STABLE_LOW to PEND_HIGH when sync_input is sampled 1, and STABLE_HIGH to PEND_LOW when sync_input is sampled 0; the stability counter is set to 1 on that edge.
REQ-015 SHALL, in a PEND state, increment the counter on each sample of the new value and return to the originating STABLE state with the counter cleared on any sample of the old value (a bounce).
REQ-016 SHALL enter the target STABLE state and update level on the edge where the new value has been sampled on STABLE_CYCLES consecutive edges; with STABLE_CYCLES=1 this is the first sampling edge, so the PEND state is never visited.
REQ-017 SHALL assert press_pulse or release_pulse in the same cycle level changes, for exactly one cycle; the two pulses are never high together.
REQ-018 SHALL size the counter to the clog2 of the largest of STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, plus 1; the counter never wraps.
REQ-019 SHALL, when REPEAT_ENABLE=1, count cycles in STABLE_HIGH starting at press_pulse, emit repeat_pulse REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles.
REQ-020 SHALL freeze the repeat count while in PEND_LOW, resume it on return to STABLE_HIGH, and clear it on entry to STABLE_LOW.
REQ-021 SHALL hold repeat_pulse at 0 permanently when REPEAT_ENABLE=0.
REQ-022 SHALL never assert repeat_pulse in the same cycle as press_pulse or release_pulse.

Reset
REQ-023 SHALL, while reset_n is 0, force asynchronously: level=DEFAULT; state=STABLE_HIGH if DEFAULT=1, else STABLE_LOW; all counters 0; all pulse outputs 0.
REQ-024 SHALL discard a pending transition if reset occurs mid-operation; no pulse is emitted on reset assertion or deassertion, even if sync_input differs from DEFAULT.
REQ-025 SHALL, after reset deassertion, qualify a sync_input that differs from DEFAULT normally under REQ-014 to REQ-016.

Structure
REQ-026 SHALL keep state encodings and the derived counter width as module-local constants; no shared package is needed.
REQ-027 SHALL place the auto-repeat logic (REQ-019 to REQ-022) in one sub-module, repeat_timer, with inputs clock, reset_n, enable, start and hold, and output tick.

Verification (STABLE_CYCLES=4, REPEAT_ENABLE=1, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated)
REQ-028 SHALL check a clean press: sync_input 0 to 1 and held -> level=1 and press_pulse high for 1 cycle, exactly 4 sampling edges after the change.
REQ-029 SHALL check bounce rejection: pattern 1,1,1,0 repeated from STABLE_LOW -> level stays 0 and no pulse ever appears.
REQ-030 SHALL check auto-repeat: hold high 30 cycles after press_pulse -> repeat_pulse at offsets 10, 13, 16, 19, 22, 25, 28; release -> release_pulse, and no further repeats.
REQ-031 SHALL check a hold-time glitch: a 2-cycle low at offset 5 -> no release_pulse, and the first repeat moves to offset 12.
REQ-032 SHALL check reset mid-PEND_HIGH (counter=2) with DEFAULT=0 -> level=0 and no pulse; input still high after release -> press_pulse 4 edges later.
REQ-033 SHALL check STABLE_CYCLES=1 with REPEAT_ENABLE=0 -> level follows sync_input one edge later, one pulse per toggle, and repeat_pulse always 0.

Source files
------------

// File: rtl/button_debouncer_repeat_timer.sv
// Auto-repeat timer: counts held-high cycles from a press and ticks after DELAY cycles,
// then every PERIOD cycles. The count freezes while hold is high and clears when disabled.
module repeat_timer #(
    parameter int DELAY  = 50000000,
    parameter int PERIOD = 10000000,
    parameter int CNT_W  = 27
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic start,
    input  logic hold,
    output logic tick
);

    typedef enum logic [1:0] {
        RT_IDLE   = 2'b00,
        RT_DELAY  = 2'b01,
        RT_PERIOD = 2'b10
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_LIM  = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LIM = CNT_W'(PERIOD);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             tick_q, tick_d;

    // Next phase, count and tick; IDLE stays quiet until a press arms the timer.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        cnt_inc_s = cnt_q + CNT_ONE;
        if (!enable) begin
            phase_d = RT_IDLE;
            cnt_d   = CNT_ZERO;
        end else if (start) begin
            phase_d = RT_DELAY;
            cnt_d   = CNT_ZERO;
        end else if (hold) begin
            phase_d = phase_q;
            cnt_d   = cnt_q;
        end else begin
            case (phase_q)
                RT_IDLE: begin
                    cnt_d = CNT_ZERO;
                end
                RT_DELAY: begin
                    if (cnt_inc_s == DELAY_LIM) begin
                        tick_d  = 1'b1;
                        cnt_d   = CNT_ZERO;
                        phase_d = RT_PERIOD;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                RT_PERIOD: begin
                    if (cnt_inc_s == PERIOD_LIM) begin
                        tick_d = 1'b1;
                        cnt_d  = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    phase_d = RT_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Timer state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= RT_IDLE;
            cnt_q   <= CNT_ZERO;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: a new level is accepted after STABLE_CYCLES consecutive samples,
// with one-cycle press/release pulses and optional auto-repeat while held high.
module button_debouncer #(
    parameter logic DEFAULT       = 1'b0,
    parameter int   STABLE_CYCLES = 1000000,
    parameter int   REPEAT_ENABLE = 0,
    parameter int   REPEAT_DELAY  = 50000000,
    parameter int   REPEAT_PERIOD = 10000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sync_input,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_ALL = (STABLE_CYCLES > MAX_RPT) ? STABLE_CYCLES : MAX_RPT;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
    localparam logic             REP_EN     = (REPEAT_ENABLE != 0);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        PEND_LOW    = 2'b11
    } state_t;

    localparam state_t RESET_STATE = DEFAULT ? STABLE_HIGH : STABLE_LOW;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_enable_s;
    logic             rpt_hold_s;
    logic             rpt_tick_s;

    // Qualification FSM: the counter holds how many consecutive samples of the new value were seen.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_input) begin
                    if (STABLE_LIM == CNT_ONE) begin
                        state_d = STABLE_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = PEND_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            PEND_HIGH: begin
                if (sync_input) begin
                    if ((cnt_q + CNT_ONE) == STABLE_LIM) begin
                        state_d = STABLE_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = STABLE_LOW;
                    cnt_d   = CNT_ZERO;
                end
            end
            STABLE_HIGH: begin
                if (!sync_input) begin
                    if (STABLE_LIM == CNT_ONE) begin
                        state_d   = STABLE_LOW;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                    end else begin
                        state_d = PEND_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            PEND_LOW: begin
                if (!sync_input) begin
                    if ((cnt_q + CNT_ONE) == STABLE_LIM) begin
                        state_d   = STABLE_LOW;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = STABLE_HIGH;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = CNT_ZERO;
                level_d = DEFAULT;
            end
        endcase
    end

    // Debouncer state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_STATE;
            cnt_q     <= CNT_ZERO;
            level_q   <= DEFAULT;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Repeat runs while the level is high; it pauses on a possible release and stops on leaving high.
    assign rpt_enable_s = REP_EN & ((state_d == STABLE_HIGH) | (state_d == PEND_LOW));
    assign rpt_hold_s   = (state_d == PEND_LOW);

    repeat_timer #(
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD),
        .CNT_W  (CNT_W)
    ) u_repeat_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (rpt_enable_s),
        .start   (press_d),
        .hold    (rpt_hold_s),
        .tick    (rpt_tick_s)
    );

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = rpt_tick_s;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: three debouncer configurations exercised with hand-computed expectations.
module tb_button_debouncer;

    logic clk;
    logic rst_a_n, in_a, lvl_a, prs_a, rel_a, rep_a;
    logic rst_b_n, in_b, lvl_b, prs_b, rel_b, rep_b;
    logic rst_c_n, in_c, lvl_c, prs_c, rel_c, rep_c;

    int checks;
    int errors;

    button_debouncer #(
        .DEFAULT(1'b0), .STABLE_CYCLES(4), .REPEAT_ENABLE(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_a (
        .clock(clk), .reset_n(rst_a_n), .sync_input(in_a), .level(lvl_a),
        .press_pulse(prs_a), .release_pulse(rel_a), .repeat_pulse(rep_a)
    );

    button_debouncer #(
        .DEFAULT(1'b0), .STABLE_CYCLES(1), .REPEAT_ENABLE(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_b (
        .clock(clk), .reset_n(rst_b_n), .sync_input(in_b), .level(lvl_b),
        .press_pulse(prs_b), .release_pulse(rel_b), .repeat_pulse(rep_b)
    );

    button_debouncer #(
        .DEFAULT(1'b1), .STABLE_CYCLES(4), .REPEAT_ENABLE(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_c (
        .clock(clk), .reset_n(rst_c_n), .sync_input(in_c), .level(lvl_c),
        .press_pulse(prs_c), .release_pulse(rel_c), .repeat_pulse(rep_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int idx,
                           input logic e_lvl, input logic e_prs, input logic e_rel, input logic e_rep);
        check({tag, "_level"}, idx, lvl_a, e_lvl);
        check({tag, "_press"}, idx, prs_a, e_prs);
        check({tag, "_release"}, idx, rel_a, e_rel);
        check({tag, "_repeat"}, idx, rep_a, e_rep);
    endtask

    logic [7:0] vec_b;
    logic       prev_b;
    logic       exp_rep;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        rst_c_n = 1'b0;
        in_a    = 1'b0;
        in_b    = 1'b0;
        in_c    = 1'b0;
        repeat (3) tick();

        // Reset values, including DEFAULT=1 instance.
        check_a("reset_a", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_c_level", 0, lvl_c, 1'b1);
        check("reset_c_release", 0, rel_c, 1'b0);
        check("reset_b_level", 0, lvl_b, 1'b0);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        rst_c_n = 1'b1;

        // DEFAULT=1 with input low at reset release: qualified normally, no pulse at deassertion.
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("c_level", k, lvl_c, (k < 4));
            check("c_release", k, rel_c, (k == 4));
            check("c_press", k, prs_c, 1'b0);
        end

        // Clean press, 30-cycle hold with auto-repeat, then release.
        in_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_a("press_wait", k, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_a("press", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            in_a = (k <= 30);
            tick();
            exp_rep = (k == 10) || (k == 13) || (k == 16) || (k == 19) ||
                      (k == 22) || (k == 25) || (k == 28);
            check_a("hold", k, (k < 34), 1'b0, (k == 34), exp_rep);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_a("after_release", k, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Bounce rejection: 1,1,1,0 repeated never reaches four consecutive highs.
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                in_a = (j < 3);
                tick();
                check_a("bounce", r * 4 + j, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        in_a = 1'b0;
        tick();

        // Hold-time glitch: two low samples at offsets 5 and 6 delay the first repeat to 12.
        in_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_a("glitch_wait", k, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_a("glitch_press", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            in_a = !((k == 5) || (k == 6) || (k >= 15));
            tick();
            check_a("glitch", k, (k < 18), 1'b0, (k == 18), (k == 12));
        end
        in_a = 1'b0;
        repeat (3) tick();

        // Reset while pending high with count 2: no pulse, then requalified after release.
        in_a = 1'b1;
        tick();
        tick();
        check_a("pend2", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_a_n = 1'b0;
        #1;
        check_a("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check_a("in_reset", k, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_a_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_a("post_reset", k, (k == 4), (k == 4), 1'b0, 1'b0);
        end

        // STABLE_CYCLES=1 without repeat: level follows input one edge later.
        vec_b  = 8'b0100_1011;
        prev_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_b = vec_b[i];
            tick();
            check("b_level", i, lvl_b, vec_b[i]);
            check("b_press", i, prs_b, vec_b[i] & ~prev_b);
            check("b_release", i, rel_b, ~vec_b[i] & prev_b);
            check("b_repeat", i, rep_b, 1'b0);
            prev_b = vec_b[i];
        end
        in_b = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("b_hold_repeat", k, rep_b, 1'b0);
            check("b_hold_level", k, lvl_b, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
